// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: EX forwarding selects,
// load-use and branch hazards, and the data-memory wait/timeout sequencer.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       resultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memWriteM,
  input  logic [1:0]       resultSrcM,
  input  logic             dmemReady,
  input  logic             errClr,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             dmemReq,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic mem_acc_m;
  logic mem_stall;
  logic lw_stall;

  assign mem_acc_m = memWriteM | (resultSrcM == 2'b01);

  // EX operand forwarding; the younger MEM result wins over WB
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regWriteM && (RdM != 5'd0) && (RdM == Rs1E))      forwardAE = 2'b10;
    else if (regWriteW && (RdW != 5'd0) && (RdW == Rs1E)) forwardAE = 2'b01;
    if (regWriteM && (RdM != 5'd0) && (RdM == Rs2E))      forwardBE = 2'b10;
    else if (regWriteW && (RdW != 5'd0) && (RdW == Rs2E)) forwardBE = 2'b01;
  end

  assign lw_stall = (resultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic for the memory handshake sequencer
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_acc_m && !dmemReady) begin
          state_d    = S_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dmemReady) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(MAX_WAIT)) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_ERROR: begin
        if (errClr) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    dmemReq   = 1'b0;
    memErr    = 1'b0;
    mem_stall = 1'b0;
    flushM    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        dmemReq   = mem_acc_m;
        mem_stall = mem_acc_m & ~dmemReady;
      end
      S_WAIT: begin
        dmemReq   = 1'b1;
        mem_stall = ~dmemReady;
      end
      S_ERROR: begin
        memErr    = 1'b1;
        mem_stall = 1'b1;
        flushM    = errClr;
      end
      default: ;
    endcase
  end

  // A held MEM stage freezes everything behind it, so D/E flushes wait it out
  assign stallM = mem_stall;
  assign stallE = mem_stall;
  assign stallF = mem_stall | lw_stall;
  assign stallD = mem_stall | lw_stall;
  assign flushW = mem_stall;
  assign flushE = ~mem_stall & (lw_stall | PCSrcE);
  assign flushD = ~mem_stall & PCSrcE;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; driver queues expected outputs, monitor checks them.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] resultSrcE, resultSrcM;
  logic       PCSrcE, regWriteM, regWriteW, memWriteM, dmemReady, errClr;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, flushW;
  logic       dmemReq, memErr;
  logic [CNT_W-1:0] stallCycles;

  typedef struct {
    string       nm;
    logic [17:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .resultSrcE(resultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .memWriteM(memWriteM),
    .resultSrcM(resultSrcM), .dmemReady(dmemReady), .errClr(errClr),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .dmemReq(dmemReq), .memErr(memErr), .stallCycles(stallCycles)
  );

  // Monitor: outputs settle mid-cycle, compare at the falling edge
  initial begin
    logic [17:0] act;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {forwardAE, forwardBE, stallF, stallD, stallE, stallM,
               flushD, flushE, flushM, flushW, dmemReq, memErr, stallCycles};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got fa_fb_stFDEM_flDEMW_req_err_cnt=%b expected %b", e.nm, act, e.exp);
        end
      end
    end
  end

  // st = {F,D,E,M}, fl = {D,E,M,W}; inputs for this cycle are already applied
  task automatic cyc(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] st, input logic [3:0] fl,
                     input logic rq, input logic er, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.nm  = nm;
    e.exp = {fa, fb, st, fl, rq, er, cnt};
    q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    resultSrcE = '0; resultSrcM = '0; PCSrcE = 1'b0; regWriteM = 1'b0;
    regWriteW = 1'b0; memWriteM = 1'b0; dmemReady = 1'b0; errClr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #1;
    cyc("reset", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;

    // Forwarding
    RdM = 5'd5; regWriteM = 1'b1; RdW = 5'd5; regWriteW = 1'b1; Rs1E = 5'd5;
    cyc("fwd_mem", 2'b10, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    Rs1E = 5'd0;
    cyc("fwd_x0", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    Rs1E = 5'd5; Rs2E = 5'd5; regWriteM = 1'b0;
    cyc("fwd_wb", 2'b01, 2'b01, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    regWriteM = 1'b1; Rs1E = 5'd3; RdW = 5'd3;
    cyc("fwd_mix", 2'b01, 2'b10, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    clear_inputs();

    // Load-use and branch
    resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    cyc("load_use", 2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0, 1'b0, 4'd0);
    RdE = 5'd0;
    cyc("load_use_x0", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);
    clear_inputs(); PCSrcE = 1'b1;
    cyc("branch", 2'b00, 2'b00, 4'b0000, 4'b1100, 1'b0, 1'b0, 4'd1);
    resultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    cyc("lw_and_branch", 2'b00, 2'b00, 4'b1100, 4'b1100, 1'b0, 1'b0, 4'd1);
    clear_inputs();

    // Store with three wait cycles
    memWriteM = 1'b1;
    cyc("mem_req", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd2);
    cyc("mem_wait1", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd3);
    cyc("mem_wait2", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd4);
    dmemReady = 1'b1;
    cyc("mem_ready", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd5);
    memWriteM = 1'b0; resultSrcM = 2'b01;
    cyc("b2b_load_ready", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd5);
    clear_inputs(); errClr = 1'b1; dmemReady = 1'b1;
    cyc("idle_ignore", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd5);
    clear_inputs();

    // Timeout into ERROR, counter saturation, then clear
    memWriteM = 1'b1;
    cyc("to_req", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd5);
    cyc("to_wait1", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd6);
    cyc("to_wait2", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd7);
    cyc("to_wait3", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd8);
    cyc("to_wait4", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd9);
    dmemReady = 1'b1;
    cyc("err_ignore_rdy", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd10);
    dmemReady = 1'b0; PCSrcE = 1'b1;
    cyc("err_branch_held", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd11);
    cyc("err_hold1", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd12);
    cyc("err_hold2", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd13);
    cyc("err_hold3", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd14);
    cyc("cnt_max", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd15);
    cyc("cnt_saturate", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'd15);
    errClr = 1'b1;
    cyc("err_clear", 2'b00, 2'b00, 4'b1111, 4'b0011, 1'b0, 1'b1, 4'd15);
    errClr = 1'b0; memWriteM = 1'b0;
    cyc("post_clr_branch", 2'b00, 2'b00, 4'b0000, 4'b1100, 1'b0, 1'b0, 4'd15);
    clear_inputs();

    // Asynchronous reset in the middle of WAIT
    memWriteM = 1'b1;
    cyc("rst_req", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd15);
    cyc("rst_wait", 2'b00, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 4'd15);
    rst_n = 1'b0; memWriteM = 1'b0;
    cyc("async_rst", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    cyc("post_rst_idle", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0);
    resultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    cyc("post_rst_lw", 2'b00, 2'b00, 4'b1100, 4'b0100, 1'b0, 1'b0, 4'd0);
    clear_inputs();
    cyc("post_rst_cnt", 2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall controller for the five-stage RISC-V pipeline. It generates stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and EX-stage operand forwarding selects. It also sequences a multi-cycle data-memory handshake: it holds the EX/MEM register while the MEM-stage access is outstanding and flags a timeout. It sits beside the datapath and drives no data, only control.

## Interface

Parameters:
- MAX_WAIT, 16: maximum cycles spent in WAIT before the timeout error; legal range 2..255.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5 each  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  5 each  execute-stage source and destination registers.
- resultSrcE  in  2  EX result select; 2'b01 marks a load.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- RdM, RdW  in  5 each  MEM and WB destination registers.
- regWriteM, regWriteW  in  1 each  register-write enables in MEM and WB.
- memWriteM  in  1  store in MEM.
- resultSrcM  in  2  MEM result select; 2'b01 marks a load.
- dmemReady  in  1  data memory completes the current access this cycle.
- errClr  in  1  single-cycle pulse that clears the timeout error.
- forwardAE, forwardBE  out  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = ALUResultM.
- stallF, stallD, stallE, stallM  out  1 each  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- flushD, flushE, flushM, flushW  out  1 each  clear IF/ID, ID/EX, EX/MEM and MEM/WB to a bubble.
- dmemReq  out  1  data-memory request, held until dmemReady.
- memErr  out  1  sticky timeout flag.
- stallCycles  out  CNT_W  saturating count of cycles with stallF = 1.

## Operation

Definitions:
- memAccM = memWriteM | (resultSrcM == 2'b01).
- memStall = (state == IDLE & memAccM & ~dmemReady) | (state == WAIT & ~dmemReady) | (state == ERROR).

Forwarding (combinational):
- forwardAE = 10 if regWriteM & RdM != 0 & RdM == Rs1E.
- Otherwise forwardAE = 01 if regWriteW & RdW != 0 & RdW == Rs1E.
- Otherwise forwardAE = 00.
- forwardBE follows the same rules using Rs2E. The MEM match has priority over the WB match.

Load-use hazard:
- lwStall = (resultSrcE == 2'b01) & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).

Output equations:
- stallM = stallE = memStall.
- stallF = stallD = memStall | lwStall.
- flushW = memStall (a bubble enters WB while MEM is held).
- flushE = ~memStall & (lwStall | PCSrcE).
- flushD = ~memStall & PCSrcE.
- flushM = errClr & (state == ERROR). The errored access is dropped.
- The memory stall has priority. While memStall = 1, no flush is issued for D or E; a pending PCSrcE stays frozen in EX and takes effect on the first cycle that is not stalled.

FSM (state register, plus waitCnt of width clog2(MAX_WAIT+1)):
- IDLE: dmemReq = memAccM. If memAccM & ~dmemReady, go to WAIT with waitCnt = 1. Otherwise stay in IDLE.
- WAIT: dmemReq = 1.
  - If dmemReady, go to IDLE with waitCnt = 0. memStall = 0 this cycle, so the instruction advances at the next edge.
  - Else if waitCnt == MAX_WAIT, go to ERROR.
  - Else waitCnt increments.
- ERROR: dmemReq = 0, memErr = 1, all stalls held. On errClr, go to IDLE, clear memErr and waitCnt, and assert flushM for that cycle.
- dmemReady is ignored in IDLE when memAccM = 0, and ignored in ERROR.

stallCycles:
- Increments on each edge where stallF = 1.
- Saturates at all-ones; no wrap.

## Timing

Reset and latency:
- Asserting rst_n = 0 immediately forces state = IDLE, waitCnt = 0, memErr = 0, stallCycles = 0, regardless of the clock.
- With all inputs at 0 during reset, every output is 0.
- Forwarding, stall and flush outputs are combinational from the current inputs and state, with zero-cycle latency.
- dmemReq is combinational and is asserted in the same cycle the access arrives in MEM.

Memory handshake:
- If dmemReady arrives in the same cycle as the request, there is no stall.
- Otherwise the stall lasts N cycles for a ready that arrives N cycles after the request (N ≤ MAX_WAIT).
- If ready has not arrived after MAX_WAIT cycles in WAIT, the state is ERROR on the next edge.

Boundary cases:
- Reset during WAIT or ERROR abandons the access; dmemReq drops as soon as rst_n is low.
- Back-to-back memory instructions: each one raises a fresh request in IDLE on the cycle after the previous access completes.
- lwStall and PCSrcE together: flushE = 1, stallF = stallD = 1, flushD = 1. The branch wins in effect, because the stalled D content is flushed.
- errClr outside ERROR has no effect.

## Test plan

- Forwarding: RdM = 5, regWriteM = 1, RdW = 5, regWriteW = 1, Rs1E = 5 -> forwardAE = 10. With Rs1E = 0 -> forwardAE = 00. With regWriteM = 0 -> forwardAE = 01.
- Load-use: resultSrcE = 01, RdE = 7, Rs2D = 7 -> stallF = stallD = flushE = 1 for one cycle, stallE = 0. With RdE = 0 -> no stall.
- Branch: PCSrcE = 1 with no memory access -> flushD = flushE = 1, all stalls = 0.
- Memory wait: store in MEM, dmemReady low for 3 cycles then high -> dmemReq high for 4 cycles, stallM = flushW = 1 for 3 cycles, stallCycles = 3, back to IDLE.
- Timeout: MAX_WAIT = 4, dmemReady held low -> ERROR after 4 WAIT cycles, memErr = 1 with stalls held. An errClr pulse -> flushM = 1 for one cycle, then IDLE with memErr = 0.
- Async reset: drive rst_n low mid-WAIT, between clock edges -> dmemReq, memErr and stallCycles go to 0 immediately, and state is IDLE after release.
